// File: rtl/hello_stream_tx_pkg.sv
// Shared constants for the "hello" byte-stream transmitter.
// ASCII characters, one-hot state codes and string length.
package hello_stream_tx_pkg;

  localparam logic [7:0] CHAR_H = 8'h68;
  localparam logic [7:0] CHAR_E = 8'h65;
  localparam logic [7:0] CHAR_L = 8'h6C;
  localparam logic [7:0] CHAR_O = 8'h6F;

  localparam int HELLO_LEN = 5;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_SEND = 4'b0010;
  localparam logic [3:0] ST_GAP  = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  typedef enum logic [3:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/hello_stream_tx_if.sv
// Valid/ready byte stream between the transmitter and its sink.
// master drives data and valid, slave drives ready.
interface hello_stream_tx_if;

  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );

endinterface

// File: rtl/hello_stream_tx_char_rom.sv
// Character lookup for the "hello" string.
// Indices past the last character return 0x00.
module hello_char_rom
  import hello_stream_tx_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] ch
);

  always_comb begin
    ch = 8'h00;
    case (idx)
      3'd0:    ch = CHAR_H;
      3'd1:    ch = CHAR_E;
      3'd2:    ch = CHAR_L;
      3'd3:    ch = CHAR_L;
      3'd4:    ch = CHAR_O;
      default: ch = 8'h00;
    endcase
  end

endmodule

// File: rtl/hello_stream_tx.sv
// Emits REPEAT copies of "hello" per start pulse on a valid/ready
// byte stream, with optional idle gap cycles after each accepted byte.
module hello_stream_tx
  import hello_stream_tx_pkg::*;
#(
  parameter int REPEAT     = 5,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  hello_stream_tx_if.master  tx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frame_count
);

  localparam logic [7:0] LAST_WORD = 8'(REPEAT - 1);
  localparam logic [2:0] LAST_CHAR = 3'(HELLO_LEN - 1);
  localparam logic [3:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_e           state, state_d;
  logic [2:0]       char_idx, char_d;
  logic [7:0]       word_cnt, word_d;
  logic [3:0]       gap_cnt, gap_d;
  logic [CNT_W-1:0] frame_d;
  logic [7:0]       data_q, data_d;

  logic [2:0] nxt_idx;
  logic [2:0] rom_idx;
  logic [7:0] rom_ch;
  logic       accept;
  logic       last_char;

  assign last_char = (char_idx == LAST_CHAR);
  assign nxt_idx   = last_char ? 3'd0 : char_idx + 3'd1;
  // In GAP char_idx already points at the byte to send next
  assign rom_idx   = (state == GAP) ? char_idx : nxt_idx;

  hello_char_rom u_rom (
    .idx (rom_idx),
    .ch  (rom_ch)
  );

  assign tx.data_out_valid = (state == SEND);
  assign tx.data_out       = data_q;
  assign busy              = (state == SEND) || (state == GAP);
  assign done              = (state == DONE);
  assign accept            = tx.data_out_valid && tx.data_out_ready;

  always_comb begin
    state_d = state;
    char_d  = char_idx;
    word_d  = word_cnt;
    gap_d   = gap_cnt;
    frame_d = frame_count;
    data_d  = data_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          char_d  = 3'd0;
          word_d  = 8'd0;
          data_d  = CHAR_H;
        end
      end
      SEND: begin
        if (accept) begin
          char_d = nxt_idx;
          if (last_char) begin
            frame_d = frame_count + CNT_W'(1);
            word_d  = word_cnt + 8'd1;
          end
          if (last_char && (word_cnt == LAST_WORD)) begin
            state_d = DONE;
          end else if (HAS_GAP) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            data_d = rom_ch;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          state_d = SEND;
          data_d  = rom_ch;
        end else begin
          gap_d = gap_cnt - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        char_d  = 3'd0;
        word_d  = 8'd0;
        gap_d   = 4'd0;
        data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      char_idx    <= 3'd0;
      word_cnt    <= 8'd0;
      gap_cnt     <= 4'd0;
      frame_count <= '0;
      data_q      <= 8'h00;
    end else begin
      state       <= state_d;
      char_idx    <= char_d;
      word_cnt    <= word_d;
      gap_cnt     <= gap_d;
      frame_count <= frame_d;
      data_q      <= data_d;
    end
  end

endmodule
